// File: rtl/riscv_rf_wb_if.sv
// Bundle of the write-back controller's bus signals: ALU result handshake, load issue/response,
// ID hazard query and the registered RF write port. clk/rst_n stay outside the bundle.
interface riscv_rf_wb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  // ALU handshake: a result transfers on a cycle where alu_valid_i & alu_ready_o are both high;
  // the producer holds valid/dst/data stable until that cycle, and ready never looks at valid.
  logic            alu_valid_i;
  logic            alu_ready_o;
  logic [AW-1:0]   alu_dst_i;
  logic [XLEN-1:0] alu_data_i;

  logic            ld_issue_i;
  logic [AW-1:0]   ld_issue_dst_i;
  logic            ld_valid_i;
  logic [AW-1:0]   ld_dst_i;
  logic [XLEN-1:0] ld_data_i;

  logic [AW-1:0]   id_src1_i;
  logic [AW-1:0]   id_src2_i;
  logic [AW-1:0]   id_dst_i;
  logic            id_dst_we_i;
  logic            id_stall_o;
  logic            fwd1_valid_o;
  logic [XLEN-1:0] fwd1_data_o;
  logic            fwd2_valid_o;
  logic [XLEN-1:0] fwd2_data_o;

  logic            rf_we_o;
  logic [AW-1:0]   rf_dst_o;
  logic [XLEN-1:0] rf_dst_d_o;
  logic            ld_err_o;

  modport slave (
    input  alu_valid_i, alu_dst_i, alu_data_i,
    input  ld_issue_i, ld_issue_dst_i, ld_valid_i, ld_dst_i, ld_data_i,
    input  id_src1_i, id_src2_i, id_dst_i, id_dst_we_i,
    output alu_ready_o, id_stall_o, fwd1_valid_o, fwd1_data_o, fwd2_valid_o, fwd2_data_o,
    output rf_we_o, rf_dst_o, rf_dst_d_o, ld_err_o
  );

  modport master (
    output alu_valid_i, alu_dst_i, alu_data_i,
    output ld_issue_i, ld_issue_dst_i, ld_valid_i, ld_dst_i, ld_data_i,
    output id_src1_i, id_src2_i, id_dst_i, id_dst_we_i,
    input  alu_ready_o, id_stall_o, fwd1_valid_o, fwd1_data_o, fwd2_valid_o, fwd2_data_o,
    input  rf_we_o, rf_dst_o, rf_dst_d_o, ld_err_o
  );
endinterface

// File: rtl/riscv_rf_wb.sv
// Register-file write-port controller: arbitrates load responses, a one-entry ALU skid and new
// ALU results onto a registered RF write, tracks pending loads and supplies ID stall/forwarding.
module riscv_rf_wb #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic           clk,
  input logic           rst_n,
  riscv_rf_wb_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  logic [NREG-1:0] pend_q, pend_d;
  logic            skid_v_q, skid_v_d;
  logic [AW-1:0]   skid_dst_q, skid_dst_d;
  logic [XLEN-1:0] skid_data_q, skid_data_d;
  logic            alu_rdy_q;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_dst_q, rf_dst_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d;
  logic            err_q, err_d;

  logic            alu_hs;
  logic            win_v;
  logic [AW-1:0]   win_dst;
  logic [XLEN-1:0] win_data;
  logic [XLEN:0]   fwd1, fwd2;

  assign alu_hs = bus.alu_valid_i & alu_rdy_q;

  // Load responses cannot be back-pressured, so they always win; a colliding ALU result parks in the skid.
  always_comb begin
    win_v       = 1'b0;
    win_dst     = '0;
    win_data    = '0;
    skid_v_d    = skid_v_q;
    skid_dst_d  = skid_dst_q;
    skid_data_d = skid_data_q;
    if (bus.ld_valid_i) begin
      win_v    = 1'b1;
      win_dst  = bus.ld_dst_i;
      win_data = bus.ld_data_i;
      if (alu_hs) begin
        skid_v_d    = 1'b1;
        skid_dst_d  = bus.alu_dst_i;
        skid_data_d = bus.alu_data_i;
      end
    end else if (skid_v_q) begin
      win_v    = 1'b1;
      win_dst  = skid_dst_q;
      win_data = skid_data_q;
      skid_v_d = 1'b0;
    end else if (alu_hs) begin
      win_v    = 1'b1;
      win_dst  = bus.alu_dst_i;
      win_data = bus.alu_data_i;
    end
  end

  always_comb begin
    rf_we_d   = win_v & (win_dst != '0);
    rf_dst_d  = win_v ? win_dst : rf_dst_q;
    rf_data_d = win_v ? win_data : rf_data_q;
  end

  // Issue is applied after the response clear so a same-register issue keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (bus.ld_valid_i) pend_d[bus.ld_dst_i] = 1'b0;
    if (bus.ld_issue_i) pend_d[bus.ld_issue_dst_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    err_d = err_q | (bus.ld_valid_i & (bus.ld_dst_i != '0) & ~pend_q[bus.ld_dst_i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q      <= '0;
      skid_v_q    <= 1'b0;
      skid_dst_q  <= '0;
      skid_data_q <= '0;
      alu_rdy_q   <= 1'b1;
      rf_we_q     <= 1'b0;
      rf_dst_q    <= '0;
      rf_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      skid_v_q    <= skid_v_d;
      skid_dst_q  <= skid_dst_d;
      skid_data_q <= skid_data_d;
      alu_rdy_q   <= ~skid_v_d;
      rf_we_q     <= rf_we_d;
      rf_dst_q    <= rf_dst_d;
      rf_data_q   <= rf_data_d;
      err_q       <= err_d;
    end
  end

  // The write in flight is newer than anything in the skid, so it is checked first.
  function automatic logic [XLEN:0] fwd_lookup(input logic [AW-1:0] s,
                                               input logic we, input logic [AW-1:0] wdst,
                                               input logic [XLEN-1:0] wdata,
                                               input logic sv, input logic [AW-1:0] sdst,
                                               input logic [XLEN-1:0] sdata);
    fwd_lookup = '0;
    if (s != '0) begin
      if (we && (wdst == s))      fwd_lookup = {1'b1, wdata};
      else if (sv && (sdst == s)) fwd_lookup = {1'b1, sdata};
    end
  endfunction

  always_comb begin
    fwd1 = fwd_lookup(bus.id_src1_i, rf_we_q, rf_dst_q, rf_data_q, skid_v_q, skid_dst_q, skid_data_q);
    fwd2 = fwd_lookup(bus.id_src2_i, rf_we_q, rf_dst_q, rf_data_q, skid_v_q, skid_dst_q, skid_data_q);
  end

  assign bus.id_stall_o   = ((bus.id_src1_i != '0) & pend_q[bus.id_src1_i])
                          | ((bus.id_src2_i != '0) & pend_q[bus.id_src2_i])
                          | (bus.id_dst_we_i & (bus.id_dst_i != '0) & pend_q[bus.id_dst_i]);
  assign bus.fwd1_valid_o = fwd1[XLEN];
  assign bus.fwd1_data_o  = fwd1[XLEN-1:0];
  assign bus.fwd2_valid_o = fwd2[XLEN];
  assign bus.fwd2_data_o  = fwd2[XLEN-1:0];
  assign bus.alu_ready_o  = alu_rdy_q;
  assign bus.rf_we_o      = rf_we_q;
  assign bus.rf_dst_o     = rf_dst_q;
  assign bus.rf_dst_d_o   = rf_data_q;
  assign bus.ld_err_o     = err_q;
endmodule

// File: tb/tb_riscv_rf_wb.sv
// Bench for riscv_rf_wb: directed vector table, one hand-written skid sequence, then random traffic
// checked against a queue/array model of the write-back rules.
module tb_riscv_rf_wb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_rf_wb_if bus ();
  riscv_rf_wb dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst_n, av;  logic [4:0] ad;  logic [31:0] adat;
    logic        li;         logic [4:0] lid;
    logic        lv;         logic [4:0] ld;  logic [31:0] ldat;
    logic [4:0]  s1;         logic dw;        logic [4:0] dd;
    logic        e_we;       logic [4:0] e_dst; logic [31:0] e_data;
    logic        e_rdy, e_stall, e_f1v;       logic [31:0] e_f1d;  logic e_err;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic av, input logic [4:0] ad, input logic [31:0] adat,
                     input logic li, input logic [4:0] lid, input logic lv, input logic [4:0] ld,
                     input logic [31:0] ldat, input logic [4:0] s1, input logic dw, input logic [4:0] dd,
                     input logic we, input logic [4:0] edst, input logic [31:0] edata, input logic rdy,
                     input logic stall, input logic f1v, input logic [31:0] f1d, input logic err);
    vec_t v;
    v = '{r, av, ad, adat, li, lid, lv, ld, ldat, s1, dw, dd, we, edst, edata, rdy, stall, f1v, f1d, err};
    tbl.push_back(v);
  endtask

  task automatic drive(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                       input logic li, input logic [4:0] lid, input logic lv, input logic [4:0] ld,
                       input logic [31:0] ldat, input logic [4:0] s1, input logic [4:0] s2,
                       input logic dw, input logic [4:0] dd);
    bus.alu_valid_i = av;  bus.alu_dst_i = ad;  bus.alu_data_i = adat;
    bus.ld_issue_i = li;   bus.ld_issue_dst_i = lid;
    bus.ld_valid_i = lv;   bus.ld_dst_i = ld;   bus.ld_data_i = ldat;
    bus.id_src1_i = s1;    bus.id_src2_i = s2;  bus.id_dst_i = dd;  bus.id_dst_we_i = dw;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { logic [4:0] d; logic [31:0] v; } wr_t;
  wr_t         m_wait[$];
  bit          m_pend[32];
  bit          m_we, m_rdy, m_err;
  logic [4:0]  m_dst;
  logic [31:0] m_data;

  function automatic void m_reset();
    m_wait.delete();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_we = 1'b0; m_rdy = 1'b1; m_err = 1'b0; m_dst = '0; m_data = '0;
  endfunction

  function automatic void m_fwd(input logic [4:0] s, output bit v, output logic [31:0] d);
    v = 1'b0; d = '0;
    if (s != 0) begin
      if (m_we && m_dst == s) begin v = 1'b1; d = m_data; end
      else foreach (m_wait[i]) if (m_wait[i].d == s) begin v = 1'b1; d = m_wait[i].v; end
    end
  endfunction

  function automatic void m_step();
    wr_t w; bit got; bit hs;
    if (!rst_n) begin m_reset(); return; end
    hs = bus.alu_valid_i && m_rdy;
    got = 1'b0; w = '{default: '0};
    if (bus.ld_valid_i) begin
      w = '{bus.ld_dst_i, bus.ld_data_i}; got = 1'b1;
      if (hs) m_wait.push_back('{bus.alu_dst_i, bus.alu_data_i});
    end else if (m_wait.size() > 0) begin
      w = m_wait.pop_front(); got = 1'b1;
    end else if (hs) begin
      w = '{bus.alu_dst_i, bus.alu_data_i}; got = 1'b1;
    end
    if (bus.ld_valid_i && bus.ld_dst_i != 0 && !m_pend[bus.ld_dst_i]) m_err = 1'b1;
    if (bus.ld_valid_i) m_pend[bus.ld_dst_i] = 1'b0;
    if (bus.ld_issue_i && bus.ld_issue_dst_i != 0) m_pend[bus.ld_issue_dst_i] = 1'b1;
    m_we = got && (w.d != 0);
    if (got) begin m_dst = w.d; m_data = w.v; end
    m_rdy = (m_wait.size() == 0);
  endfunction

  task automatic m_check();
    bit v1, v2, stall;
    logic [31:0] d1, d2;
    m_fwd(bus.id_src1_i, v1, d1);
    m_fwd(bus.id_src2_i, v2, d2);
    stall = (bus.id_src1_i != 0 && m_pend[bus.id_src1_i]) || (bus.id_src2_i != 0 && m_pend[bus.id_src2_i])
         || (bus.id_dst_we_i && bus.id_dst_i != 0 && m_pend[bus.id_dst_i]);
    chk("rnd_rf_we", bus.rf_we_o, m_we);
    if (m_we) begin
      chk("rnd_rf_dst", bus.rf_dst_o, m_dst);
      chk("rnd_rf_data", bus.rf_dst_d_o, m_data);
    end
    chk("rnd_alu_ready", bus.alu_ready_o, m_rdy);
    chk("rnd_stall", bus.id_stall_o, stall);
    chk("rnd_fwd1_valid", bus.fwd1_valid_o, v1);
    if (v1) chk("rnd_fwd1_data", bus.fwd1_data_o, d1);
    chk("rnd_fwd2_valid", bus.fwd2_valid_o, v2);
    if (v2) chk("rnd_fwd2_data", bus.fwd2_data_o, d2);
    chk("rnd_ld_err", bus.ld_err_o, m_err);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    next_cycle();
    next_cycle();

    //   rst av ad adat          li lid lv ld ldat          s1 dw dd | we dst data        rdy st f1v f1d          err
    add(1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 0,   0, 0, 32'h0,        1, 0, 0, 32'h0,        0);
    add(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        0, 0, 0,   0, 0, 32'h0,        1, 0, 0, 32'h0,        0);
    add(1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        5, 0, 0,   1, 5, 32'hDEADBEEF, 1, 0, 1, 32'hDEADBEEF, 0);
    add(1, 0, 0, 32'h0,        1, 7, 0, 0, 32'h0,        0, 0, 0,   0, 0, 32'h0,        1, 0, 0, 32'h0,        0);
    add(1, 1, 3, 32'h11,       0, 0, 1, 7, 32'h22,       7, 0, 0,   0, 0, 32'h0,        1, 1, 0, 32'h0,        0);
    add(1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        3, 0, 0,   1, 7, 32'h22,       0, 0, 1, 32'h11,       0);
    add(1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        3, 0, 0,   1, 3, 32'h11,       1, 0, 1, 32'h11,       0);
    add(1, 0, 0, 32'h0,        1, 9, 0, 0, 32'h0,        9, 0, 0,   0, 0, 32'h0,        1, 0, 0, 32'h0,        0);
    add(1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        9, 0, 0,   0, 0, 32'h0,        1, 1, 0, 32'h0,        0);
    add(1, 0, 0, 32'h0,        0, 0, 1, 9, 32'hCAFE0009, 9, 0, 0,   0, 0, 32'h0,        1, 1, 0, 32'h0,        0);
    add(1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        9, 0, 0,   1, 9, 32'hCAFE0009, 1, 0, 1, 32'hCAFE0009, 0);
    add(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h0,        0, 0, 0,   0, 0, 32'h0,        1, 0, 0, 32'h0,        0);
    add(1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 0,   0, 0, 32'h0,        1, 0, 0, 32'h0,        0);
    add(1, 0, 0, 32'h0,        0, 0, 1, 12, 32'h1234,    0, 0, 0,   0, 0, 32'h0,        1, 0, 0, 32'h0,        0);
    add(1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        12, 0, 0,  1, 12, 32'h1234,    1, 0, 1, 32'h1234,     1);
    add(1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 0,   0, 0, 32'h0,        1, 0, 0, 32'h0,        1);
    add(1, 0, 0, 32'h0,        1, 4, 0, 0, 32'h0,        0, 0, 0,   0, 0, 32'h0,        1, 0, 0, 32'h0,        1);
    add(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        4, 0, 0,   0, 0, 32'h0,        1, 1, 0, 32'h0,        1);
    add(1, 0, 0, 32'h0,        0, 0, 1, 4, 32'h44,       4, 0, 0,   0, 0, 32'h0,        1, 0, 0, 32'h0,        0);
    add(1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        4, 0, 0,   1, 4, 32'h44,       1, 0, 1, 32'h44,       1);
    add(1, 0, 0, 32'h0,        1, 6, 0, 0, 32'h0,        0, 0, 0,   0, 0, 32'h0,        1, 0, 0, 32'h0,        1);
    add(1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 1, 6,   0, 0, 32'h0,        1, 1, 0, 32'h0,        1);
    add(1, 0, 0, 32'h0,        0, 0, 1, 6, 32'h66,       0, 1, 6,   0, 0, 32'h0,        1, 1, 0, 32'h0,        1);
    add(1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 1, 6,   1, 6, 32'h66,       1, 0, 0, 32'h0,        1);
    add(1, 0, 0, 32'h0,        1, 8, 0, 0, 32'h0,        0, 0, 0,   0, 0, 32'h0,        1, 0, 0, 32'h0,        1);
    add(1, 0, 0, 32'h0,        1, 8, 1, 8, 32'h88,       0, 0, 0,   0, 0, 32'h0,        1, 0, 0, 32'h0,        1);
    add(1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        8, 0, 0,   1, 8, 32'h88,       1, 1, 1, 32'h88,       1);

    chk("reset_rf_dst", bus.rf_dst_o, 5'd0);
    chk("reset_rf_data", bus.rf_dst_d_o, 32'h0);
    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n;
      drive(tbl[i].av, tbl[i].ad, tbl[i].adat, tbl[i].li, tbl[i].lid, tbl[i].lv, tbl[i].ld,
            tbl[i].ldat, tbl[i].s1, tbl[i].s1, tbl[i].dw, tbl[i].dd);
      @(negedge clk);
      chk($sformatf("vec%0d_rf_we", i), bus.rf_we_o, tbl[i].e_we);
      if (tbl[i].e_we) begin
        chk($sformatf("vec%0d_rf_dst", i), bus.rf_dst_o, tbl[i].e_dst);
        chk($sformatf("vec%0d_rf_data", i), bus.rf_dst_d_o, tbl[i].e_data);
      end
      chk($sformatf("vec%0d_alu_ready", i), bus.alu_ready_o, tbl[i].e_rdy);
      chk($sformatf("vec%0d_stall", i), bus.id_stall_o, tbl[i].e_stall);
      chk($sformatf("vec%0d_fwd1_valid", i), bus.fwd1_valid_o, tbl[i].e_f1v);
      chk($sformatf("vec%0d_fwd2_valid", i), bus.fwd2_valid_o, tbl[i].e_f1v);
      if (tbl[i].e_f1v) begin
        chk($sformatf("vec%0d_fwd1_data", i), bus.fwd1_data_o, tbl[i].e_f1d);
        chk($sformatf("vec%0d_fwd2_data", i), bus.fwd2_data_o, tbl[i].e_f1d);
      end
      chk($sformatf("vec%0d_ld_err", i), bus.ld_err_o, tbl[i].e_err);
      next_cycle();
    end

    // Skid held across a second load response, then drained once responses stop.
    rst_n = 1'b1;
    drive(1, 2, 32'hA2, 0, 0, 1, 10, 32'hB10, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 1, 11, 32'hB11, 2, 0, 0, 0);
    @(negedge clk);
    chk("skid_hold_ready", bus.alu_ready_o, 1'b0);
    chk("skid_hold_dst", bus.rf_dst_o, 5'd10);
    chk("skid_hold_fwd", bus.fwd1_data_o, 32'hA2);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("skid_hold2_ready", bus.alu_ready_o, 1'b0);
    chk("skid_hold2_dst", bus.rf_dst_o, 5'd11);
    next_cycle();
    @(negedge clk);
    chk("skid_drain_ready", bus.alu_ready_o, 1'b1);
    chk("skid_drain_we", bus.rf_we_o, 1'b1);
    chk("skid_drain_dst", bus.rf_dst_o, 5'd2);
    chk("skid_drain_data", bus.rf_dst_d_o, 32'hA2);
    next_cycle();

    // Random traffic against the model.
    rst_n = 1'b0;
    next_cycle();
    m_reset();
    begin
      bit          hold;
      logic        av;
      logic [4:0]  ad, ld;
      logic [31:0] adat;
      int          pl[$];
      hold = 1'b0; av = 1'b0; ad = '0; adat = '0;
      for (int c = 0; c < 3000; c++) begin
        rst_n = ($urandom_range(0, 99) != 0);
        if (!hold) begin
          av = 1'($urandom_range(0, 1));
          ad = 5'($urandom_range(0, 7));
          adat = $urandom;
        end
        pl.delete();
        for (int r = 1; r < 8; r++) if (m_pend[r]) pl.push_back(r);
        if (pl.size() > 0 && $urandom_range(0, 4) != 0) ld = 5'(pl[$urandom_range(0, pl.size() - 1)]);
        else ld = 5'($urandom_range(0, 7));
        drive(av, ad, adat, 1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 2) == 0), ld, $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
        @(negedge clk);
        m_check();
        hold = rst_n && av && !m_rdy;
        m_step();
        next_cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
